// File: rtl/md5_cmd_assembler_pkg.sv
// Shared opcodes, lengths, error codes and state encodings for the MD5 command front end.
// Also provides helpers for header validation and saturating error counting.
package md5_cmd_assembler_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;
  localparam logic [7:0] OP_NOP   = 8'h04;

  localparam logic [7:0] LEN_LOAD = 8'd4;
  localparam logic [7:0] LEN_CTRL = 8'd0;

  typedef enum logic [3:0] {
    ERR_OK        = 4'd0,
    ERR_BAD_OP    = 4'd1,
    ERR_TIMEOUT   = 4'd2,
    ERR_NO_TARGET = 4'd3,
    ERR_BUSY      = 4'd4,
    ERR_CHECKSUM  = 4'd5
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  // A header is accepted only when its length matches the opcode's fixed payload size.
  function automatic logic hdr_ok(input logic [7:0] op, input logic [7:0] len);
    case (op)
      OP_LOAD:                  return len == LEN_LOAD;
      OP_START, OP_STOP, OP_NOP: return len == LEN_CTRL;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/md5_cmd_assembler_if.sv
// Word stream, brute-forcer status and command/response signals of the command assembler.
// master = the side driving words and core status; slave = the assembler.
interface md5_cmd_assembler_if;
  logic         word_valid;
  logic [31:0]  word_in;
  logic         core_busy;
  logic         core_match;
  logic [127:0] target;
  logic         target_valid;
  logic         start_pulse;
  logic         stop_pulse;
  logic [31:0]  resp_word;

  modport master (
    output word_valid, word_in, core_busy, core_match,
    input  target, target_valid, start_pulse, stop_pulse, resp_word
  );

  modport slave (
    input  word_valid, word_in, core_busy, core_match,
    output target, target_valid, start_pulse, stop_pulse, resp_word
  );
endinterface

// File: rtl/md5_cmd_assembler_cmd_watchdog.sv
// Inter-word watchdog: counts idle cycles while enabled, expires at TIMEOUT_CYCLES.
// Clearing or disabling returns the count to zero.
module cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int          TIMEOUT_W      = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;

  assign o_expired = (r_count == TIMEOUT_W'(TIMEOUT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/md5_cmd_assembler.sv
// Command front end: parses framed words, assembles the target digest, pulses start/stop.
// Optional MD5_CMD_CHECKSUM_EN adds a trailing XOR word checked in the CHECK state.
module md5_cmd_assembler
  import md5_cmd_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int          TIMEOUT_W      = 26,
  parameter logic [7:0]  RESP_MAGIC     = 8'hA5
) (
  input logic               clk,
  input logic               rst_n,
  md5_cmd_assembler_if.slave bus
);

`ifdef MD5_CMD_CHECKSUM_EN
  localparam state_e ST_FRAME_END = ST_CHECK;
`else
  localparam state_e ST_FRAME_END = ST_COMMIT;
`endif

  state_e       r_state, w_state_next;
  logic [7:0]   r_op;
  logic [2:0]   r_remain;
  logic [127:0] r_shadow;
  logic [127:0] r_target;
  logic         r_target_valid;
  logic         r_start, r_stop;
  logic [7:0]   r_err_count;
  err_e         r_last_err, w_last_err_next;
  logic [7:0]   r_last_op;
  logic [31:0]  r_resp;

  logic         w_hdr_take, w_hdr_good, w_hdr_bad;
  logic         w_shift, w_commit, w_timeout, w_chk_bad;
  logic         w_commit_bad, w_start_ok;
  err_e         w_commit_code;
  logic [1:0]   w_err_inc;
  logic         w_expired, w_wd_enable;
  logic [7:0]   w_op_in, w_len_in;
  logic         w_unused;

  assign w_op_in  = bus.word_in[31:24];
  assign w_len_in = bus.word_in[23:16];
  assign w_unused = &{1'b0, bus.word_in[15:0]};

  assign w_wd_enable = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

  cmd_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (bus.word_valid),
    .i_enable  (w_wd_enable),
    .o_expired (w_expired)
  );

`ifdef MD5_CMD_CHECKSUM_EN
  logic [31:0] r_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_xor <= '0;
    else if (w_hdr_take) r_xor <= bus.word_in;
    else if (w_shift)    r_xor <= r_xor ^ bus.word_in;
  end
`endif

  always_comb begin
    // NOTE: defaults first on every combinational output so no path leaves one unassigned (no latch).
    w_state_next = r_state;
    w_hdr_take   = 1'b0;
    w_shift      = 1'b0;
    w_commit     = 1'b0;
    w_timeout    = 1'b0;
    w_chk_bad    = 1'b0;
    case (r_state)
      ST_IDLE: w_hdr_take = bus.word_valid;
      ST_PAYLOAD: begin
        if (bus.word_valid) begin
          w_shift = 1'b1;
          if (r_remain == 3'd1) w_state_next = ST_FRAME_END;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
`ifdef MD5_CMD_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.word_valid) begin
          if (bus.word_in == r_xor) begin
            w_state_next = ST_COMMIT;
          end else begin
            w_chk_bad    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
`endif
      ST_COMMIT: begin
        // A word landing here is the next frame's header, so it is parsed rather than dropped.
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
        w_hdr_take   = bus.word_valid;
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_hdr_good = w_hdr_take && hdr_ok(w_op_in, w_len_in);
    w_hdr_bad  = w_hdr_take && !w_hdr_good;
    if (w_hdr_take) begin
      if (!w_hdr_good)          w_state_next = ST_IDLE;
      else if (w_len_in != 8'd0) w_state_next = ST_PAYLOAD;
      else                      w_state_next = ST_FRAME_END;
    end
  end

  always_comb begin
    w_start_ok    = 1'b0;
    w_commit_bad  = 1'b0;
    w_commit_code = ERR_OK;
    if (w_commit && (r_op == OP_START)) begin
      if (!r_target_valid) begin
        w_commit_bad  = 1'b1;
        w_commit_code = ERR_NO_TARGET;
      end else if (bus.core_busy) begin
        w_commit_bad  = 1'b1;
        w_commit_code = ERR_BUSY;
      end else begin
        w_start_ok = 1'b1;
      end
    end

    // A header error in the commit cycle is the newer event, so it wins last_err.
    w_last_err_next = r_last_err;
    if (w_commit)  w_last_err_next = w_commit_code;
    if (w_timeout) w_last_err_next = ERR_TIMEOUT;
    if (w_chk_bad) w_last_err_next = ERR_CHECKSUM;
    if (w_hdr_bad) w_last_err_next = ERR_BAD_OP;

    w_err_inc = 2'(w_commit_bad) + 2'(w_hdr_bad) + 2'(w_timeout) + 2'(w_chk_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= '0;
      r_remain       <= '0;
      r_shadow       <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_start        <= 1'b0;
      r_stop         <= 1'b0;
      r_err_count    <= '0;
      r_last_err     <= ERR_OK;
      r_last_op      <= '0;
      r_resp         <= {RESP_MAGIC, 24'd0};
    end else begin
      r_start     <= w_start_ok;
      r_stop      <= w_commit && (r_op == OP_STOP);
      r_err_count <= sat_add(r_err_count, w_err_inc);
      r_last_err  <= w_last_err_next;
      r_resp      <= {RESP_MAGIC, r_err_count, r_last_err, 2'b00,
                      bus.core_busy, bus.core_match, r_last_op};

      if (w_commit && (r_op == OP_LOAD)) begin
        r_target       <= r_shadow;
        r_target_valid <= 1'b1;
      end

      if (w_shift) begin
        r_shadow <= {r_shadow[95:0], bus.word_in};
        r_remain <= r_remain - 3'd1;
      end

      if (w_hdr_good) begin
        r_op      <= w_op_in;
        r_last_op <= w_op_in;
        r_remain  <= w_len_in[2:0];
        if (w_op_in == OP_LOAD) r_target_valid <= 1'b0;
      end
    end
  end

  assign bus.target       = r_target;
  assign bus.target_valid = r_target_valid;
  assign bus.start_pulse  = r_start;
  assign bus.stop_pulse   = r_stop;
  assign bus.resp_word    = r_resp;

endmodule
